// File: rtl/fifo_rd_ctrl.sv
// Avalon-MM read-side controller for an external non-show-ahead FIFO.
// Prefetches one word into a hold register, with status, threshold and IRQ.
module fifo_rd_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned USEDW_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               read_n,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               fifo_rdreq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;
  localparam int unsigned FIELD_LSB  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_valid;
  logic                r_underrun;
  logic                r_enable;
  logic [2:0]          r_irq_mask;
  logic [USEDW_W-1:0]  r_threshold;
  logic [DATA_W-1:0]   r_hold;
  logic [31:0]         r_readdata;
  logic                r_rdreq;

  logic        w_rd;
  logic        w_wr;
  logic        w_rd_data;
  logic        w_fetch_ok;
  logic        w_capture;
  logic        w_clr_valid;
  logic        w_thr_hit;
  logic [31:0] w_rdata;
  logic        w_unused_wdata;

  assign w_rd       = chipselect & ~read_n;
  assign w_wr       = chipselect & ~write_n;
  assign w_rd_data  = w_rd & (address == ADDR_DATA);
  assign w_fetch_ok = r_enable & ~fifo_empty;
  assign w_thr_hit  = (r_threshold != '0) && (fifo_usedw >= r_threshold);
  assign w_unused_wdata = ^writedata;

  // Fetch sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch sequencer next-state; an in-flight fetch always runs through to HOLD
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clr_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fetch_ok) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_rd_data) begin
          w_clr_valid = 1'b1;
          w_state_nxt = w_fetch_ok ? S_REQ : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pop request is registered so it is high exactly while the FSM sits in REQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdreq <= 1'b0;
    end else begin
      r_rdreq <= (w_state_nxt == S_REQ);
    end
  end

  // Hold register and valid flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_hold  <= fifo_q;
      r_valid <= 1'b1;
    end else if (w_clr_valid) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky underrun; a new underrun beats a simultaneous W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (w_rd_data && !r_valid) begin
      r_underrun <= 1'b1;
    end else if (w_wr && (address == ADDR_STATUS) && writedata[1]) begin
      r_underrun <= 1'b0;
    end
  end

  // Control and mask registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask  <= '0;
      r_enable    <= 1'b0;
      r_threshold <= '0;
    end else if (w_wr) begin
      if (address == ADDR_MASK) begin
        r_irq_mask <= writedata[2:0];
      end
      if (address == ADDR_CTRL) begin
        r_enable    <= writedata[0];
        r_threshold <= writedata[FIELD_LSB +: USEDW_W];
      end
    end
  end

  // Read mux
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: w_rdata = 32'(r_hold);
      ADDR_STATUS: begin
        w_rdata[0] = r_valid;
        w_rdata[1] = r_underrun;
        w_rdata[2] = fifo_empty;
        w_rdata[3] = w_thr_hit;
        w_rdata[FIELD_LSB +: USEDW_W] = fifo_usedw;
      end
      ADDR_MASK: w_rdata[2:0] = r_irq_mask;
      ADDR_CTRL: begin
        w_rdata[0] = r_enable;
        w_rdata[FIELD_LSB +: USEDW_W] = r_threshold;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata   = r_readdata;
  assign fifo_rdreq = r_rdreq;
  assign irq        = |({r_underrun, w_thr_hit, r_valid} & r_irq_mask);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: behavioural FIFO plus a data scoreboard.
module tb_fifo_rd_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned USEDW_W = 10;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [1:0]         address = '0;
  logic               chipselect = 1'b0;
  logic               read_n = 1'b1;
  logic               write_n = 1'b1;
  logic [31:0]        writedata = '0;
  logic [31:0]        readdata;
  logic               irq;
  logic               fifo_empty;
  logic [USEDW_W-1:0] fifo_usedw;
  logic [DATA_W-1:0]  fifo_q = '0;
  logic               fifo_rdreq;

  // FIFO model: main process owns mem/wp, the clocked process owns rp/pops
  logic [DATA_W-1:0]  mem [0:63];
  int                 wp = 0;
  int                 rp = 0;
  int                 pops = 0;
  logic               ovr_en = 1'b0;
  logic [USEDW_W-1:0] ovr_val = '0;

  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;

  fifo_rd_ctrl #(.DATA_W(DATA_W), .USEDW_W(USEDW_W)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  assign fifo_usedw = ovr_en ? ovr_val : USEDW_W'(wp - rp);

  always @(posedge clk) begin
    if (fifo_rdreq && (wp != rp)) begin
      fifo_q <= mem[rp[5:0]];
      rp     <= rp + 1;
      pops   <= pops + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wp[5:0]] = w;
    wp = wp + 1;
    exp_q.push_back(w);
  endtask

  // Bus tasks are called at a negedge and return at the following negedge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic wait_valid();
    logic [31:0] st;
    st = '0;
    for (int i = 0; i < 20; i++) begin
      bus_read(2'd1, st);
      if (st[0]) break;
    end
    check_eq("wait_valid", 32'(st[0]), 32'd1);
  endtask

  task automatic read_data_sb(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    bus_read(2'd0, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_eq(tag, d, e);
  endtask

  initial begin
    logic [31:0] d;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_rdreq", 32'(fifo_rdreq), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, d); check_eq("rst_status", d, 32'h4);
    bus_read(2'd3, d); check_eq("rst_ctrl", d, 32'h0);
    bus_read(2'd2, d); check_eq("rst_mask", d, 32'h0);

    // Single fetch with cycle-exact rdreq / valid timing
    push_word(32'hA5);
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'h1);
    check_eq("f_rdreq_c0", 32'(fifo_rdreq), 32'h0);
    @(negedge clk);
    check_eq("f_rdreq_c1", 32'(fifo_rdreq), 32'h1);
    check_eq("f_irq_c1", 32'(irq), 32'h0);
    @(negedge clk);
    check_eq("f_rdreq_c2", 32'(fifo_rdreq), 32'h0);
    check_eq("f_irq_c2", 32'(irq), 32'h0);
    @(negedge clk);
    check_eq("f_valid_c3", 32'(irq), 32'h1);
    read_data_sb("f_data");
    check_eq("f_pops", 32'(pops), 32'd1);

    // Back-to-back drain of three words
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      read_data_sb("drain_data");
    end
    repeat (6) @(negedge clk);
    check_eq("drain_pops", 32'(pops), 32'd4);
    check_eq("drain_rdreq", 32'(fifo_rdreq), 32'h0);
    bus_read(2'd1, d); check_eq("drain_status", d, 32'h4);

    // Underrun
    bus_write(2'd2, 32'h4);
    bus_read(2'd0, d); check_eq("ur_data", d, 32'h33);
    check_eq("ur_pops", 32'(pops), 32'd4);
    bus_read(2'd1, d); check_eq("ur_status", d, 32'h6);
    check_eq("ur_irq", 32'(irq), 32'h1);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, d); check_eq("ur_clr_status", d, 32'h4);
    check_eq("ur_clr_irq", 32'(irq), 32'h0);

    // Threshold interrupt
    bus_write(2'd3, 32'h0008_0000);
    bus_write(2'd2, 32'h2);
    ovr_en = 1'b1; ovr_val = 10'd7;
    #1 check_eq("thr_irq_7", 32'(irq), 32'h0);
    ovr_val = 10'd8;
    #1 check_eq("thr_irq_8", 32'(irq), 32'h1);
    @(negedge clk);
    bus_read(2'd1, d); check_eq("thr_status", d, 32'h0008_000C);
    ovr_val = 10'd9;
    #1 check_eq("thr_irq_9", 32'(irq), 32'h1);
    @(negedge clk);
    bus_read(2'd3, d); check_eq("thr_ctrl", d, 32'h0008_0000);
    bus_write(2'd3, 32'h0);
    check_eq("thr_zero_irq", 32'(irq), 32'h0);
    ovr_en = 1'b0;

    // Disable in the REQ cycle: fetch completes, nothing further is popped
    bus_write(2'd2, 32'h1);
    push_word(32'h5A); push_word(32'h6B);
    bus_write(2'd3, 32'h1);
    @(negedge clk);
    check_eq("dis_rdreq", 32'(fifo_rdreq), 32'h1);
    bus_write(2'd3, 32'h0);
    wait_valid();
    read_data_sb("dis_data");
    repeat (8) @(negedge clk);
    check_eq("dis_pops", 32'(pops), 32'd5);
    check_eq("dis_rdreq_after", 32'(fifo_rdreq), 32'h0);
    bus_read(2'd1, d); check_eq("dis_status", d, 32'h0001_0000);

    // Reset while in WAIT: word is discarded, registers cleared
    bus_write(2'd3, 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("wrst_rdreq", 32'(fifo_rdreq), 32'h0);
    check_eq("wrst_irq", 32'(irq), 32'h0);
    check_eq("wrst_readdata", readdata, 32'h0);
    check_eq("wrst_pops", 32'(pops), 32'd6);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, d); check_eq("wrst_status", d, 32'h4);
    bus_read(2'd3, d); check_eq("wrst_ctrl", d, 32'h0);
    bus_read(2'd2, d); check_eq("wrst_mask", d, 32'h0);
    repeat (5) @(negedge clk);
    check_eq("wrst_no_retry", 32'(pops), 32'd6);
    bus_read(2'd0, d); check_eq("wrst_hold", d, 32'h0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: FIFO word width; SHALL be 1..32.
REQ-002 Parameter USEDW_W, default 10: FIFO fill-level width; SHALL be 1..16.
REQ-003 clk  in  1  clock; all logic SHALL be sampled on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 address  in  2  Avalon-MM word address: 0 DATA, 1 STATUS, 2 IRQ_MASK, 3 CTRL.
REQ-006 chipselect  in  1  slave select; qualifies read_n and write_n.
REQ-007 read_n  in  1  active-low read strobe.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  registered read data.
REQ-011 irq  out  1  level interrupt to CPU.
REQ-012 fifo_empty  in  1  external FIFO empty flag.
REQ-013 fifo_usedw  in  USEDW_W  external FIFO fill level.
REQ-014 fifo_q  in  DATA_W  FIFO output word, valid 1 cycle after fifo_rdreq (non-show-ahead).
REQ-015 fifo_rdreq  out  1  FIFO pop request, single-cycle pulse.

Function
REQ-016 Read strobe rd = chipselect & ~read_n; write strobe wr = chipselect & ~write_n.
REQ-017 readdata SHALL update every clock from the address-selected mux; read latency is 1 cycle.
REQ-018 DATA reads return hold_data zero-extended to 32 bits; other addresses follow REQ-024 to REQ-026.
REQ-019 FSM states SHALL be IDLE, REQ, WAIT and HOLD.
REQ-020 IDLE: if enable=1 and fifo_empty=0, go to REQ; otherwise stay in IDLE.
REQ-021 REQ: drive fifo_rdreq=1 for exactly this cycle, then go to WAIT; fifo_rdreq SHALL be 0 in all other states.
REQ-022 WAIT: capture fifo_q into hold_data, set valid=1 and go to HOLD.
- The fetch latency from IDLE to valid is 3 cycles.
REQ-023 HOLD: rd at address 0 clears valid; the next state is REQ if enable=1 and fifo_empty=0, else IDLE.
- Without that read, stay in HOLD and keep hold_data stable.
REQ-024 rd at address 0 with valid=0 returns hold_data unchanged, sets sticky underrun=1, and SHALL NOT pop the FIFO.
REQ-025 STATUS read value:
- bit0 valid, bit1 underrun, bit2 fifo_empty, bit3 thr_hit.
- bits[15+USEDW_W:16] fifo_usedw.
- All other bits 0.
REQ-026 A STATUS write with writedata[1]=1 clears underrun (write-1-to-clear).
- A simultaneous underrun set wins over the clear.
REQ-027 IRQ_MASK[2:0] is read/write; the unused bits read 0.
REQ-028 CTRL is read/write:
- bit0 enable.
- bits[15+USEDW_W:16] threshold.
- The unused bits read 0.
REQ-029 thr_hit = (threshold != 0) & (fifo_usedw >= threshold), compared unsigned.
REQ-030 irq = |({underrun, thr_hit, valid} & irq_mask[2:0]); irq is combinational from registered state and inputs.
REQ-031 Clearing enable SHALL NOT abort REQ or WAIT; a fetch already in flight completes into HOLD.
REQ-032 A write to CTRL in the same cycle as a DATA read SHALL apply both; the new enable is used from the next cycle.
REQ-033 Writes to DATA are ignored; rd and wr in the same cycle SHALL each take effect per address.

Reset
REQ-034 Asynchronous reset SHALL set the following, including mid-fetch:
- state=IDLE, fifo_rdreq=0, valid=0, underrun=0.
- hold_data=0, irq_mask=0, enable=0, threshold=0, readdata=0.
REQ-035 With irq_mask=0 after reset, irq SHALL be 0.
REQ-036 A fetch interrupted by reset SHALL NOT be retried; the popped word is discarded.

Verification
REQ-037 Fetch: FIFO holds 0xA5, CTRL=1 -> fifo_rdreq pulses 1 cycle later, valid=1 on cycle 3, and a DATA read returns 0x000000A5.
REQ-038 Back-to-back drain: 3 words, each read once HOLD is reached -> exactly 3 rdreq pulses, data in order, then IDLE with fifo_empty=1.
REQ-039 Underrun: DATA read with valid=0 and IRQ_MASK=4 -> no rdreq, STATUS bit1=1, irq=1; STATUS write 0x2 -> bit1=0, irq=0.
REQ-040 Threshold: CTRL threshold=8, IRQ_MASK=2, usedw 7 -> 8 -> irq 0 -> 1; threshold=0 -> irq=0.
REQ-041 Disable mid-fetch: enable cleared in the REQ cycle -> word still lands in HOLD and no further rdreq after the DATA read.
REQ-042 Reset in WAIT -> all registers 0, state IDLE, irq=0, fifo_rdreq=0 immediately.
